// File: rtl/bcd_sub_seq_if.sv
// Request/result bundle for the digit-serial BCD subtractor.
interface bcd_sub_seq_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, err, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, err, busy, done
  );
endinterface

// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
module bcd_sub_seq #(
  parameter int unsigned DIGITS = 4
) (
  input logic         clk,
  input logic         rst,
  bcd_sub_seq_if.slave bus
);
  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic [W-1:0]  diff_q;
  logic [CW-1:0] cnt;
  logic          br;
  logic          bad;
  logic          bout_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;

  logic          accept_c;
  logic          last_c;
  logic          busy_d;
  logic          done_d;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    dig;
  logic [5:0]    t;
  logic          br_nxt;
  logic          bad_nxt;
  logic [W-1:0]  res_nxt;

  assign accept_c = bus.start && ((state == IDLE) || (state == DONE));
  assign last_c   = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_c) state_nxt = RUN;
      RUN:     if (last_c)   state_nxt = DONE;
      DONE:    state_nxt = accept_c ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state, registered below
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_nxt == RUN);
    done_d = (state_nxt == DONE);
  end

  // One-digit subtract with decimal borrow correction
  always_comb begin
    a_dig   = a_sh[3:0];
    b_dig   = b_sh[3:0];
    t       = {2'b00, a_dig} - {2'b00, b_dig} - {5'b00000, br};
    br_nxt  = t[5];
    dig     = t[5] ? (t[3:0] + 4'd10) : t[3:0];
    bad_nxt = bad | (a_dig > 4'd9) | (b_dig > 4'd9);
    res_nxt = W'({dig, res} >> 4);
  end

  // Operand shifters, working result and held outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bad    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept_c) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        br   <= bus.bin;
        res  <= '0;
        cnt  <= '0;
        bad  <= 1'b0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 4;
        b_sh <= b_sh >> 4;
        res  <= res_nxt;
        cnt  <= cnt + CW'(1);
        br   <= br_nxt;
        bad  <= bad_nxt;
        if (last_c) begin
          diff_q <= bad_nxt ? '0 : res_nxt;
          bout_q <= br_nxt & ~bad_nxt;
          err_q  <= bad_nxt;
        end
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
